// File: rtl/mmu_mem_pkg.sv
// Shared types and helpers for the MMU memory responder.
package mmu_mem_pkg;

    // Width of the per-entry latency down-counter (covers LAT up to 15).
    localparam int unsigned LAT_W = 4;

    // Widest line address the range-check helper accepts.
    localparam int unsigned PCN_MAX_W = 64;

    // Per-entry control fields; tag and line data live in separate arrays in the queue.
    typedef struct packed {
        logic             wnr;
        logic             err;
        logic [LAT_W-1:0] cnt;
    } entry_ctrl_t;

    // A line address is out of range when any bit above the array index is set.
    function automatic logic pcn_err(input logic [PCN_MAX_W-1:0] pcn, input int unsigned aw);
        return |(pcn >> aw);
    endfunction

endpackage

// File: rtl/mmu_mem_rsp_q.sv
// In-order response FIFO whose entries count down a fixed latency before the head may leave.
module mmu_mem_rsp_q
    import mmu_mem_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned IdxW  = 4,
    parameter int unsigned DataW = 512,
    parameter int unsigned Lat   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [IdxW-1:0]  push_idx_i,
    input  logic             push_wnr_i,
    input  logic             push_err_i,
    input  logic [DataW-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             head_ready_o,
    output logic [IdxW-1:0]  head_idx_o,
    output logic             head_wnr_o,
    output logic             head_err_o,
    output logic [DataW-1:0] head_data_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned OccW = PtrW + 1;

    entry_ctrl_t      ctrl_q [Depth];
    logic [IdxW-1:0]  idx_q  [Depth];
    logic [DataW-1:0] data_q [Depth];
    logic [Depth-1:0] vld_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [OccW-1:0]  occ_q;
    logic [OccW-1:0]  occ_d;

    // No full-bypass: a pop in the same cycle does not make room for a push.
    assign full_o       = (occ_q == OccW'(Depth));
    assign head_ready_o = vld_q[rd_ptr_q] && (ctrl_q[rd_ptr_q].cnt == '0);
    assign head_idx_o   = idx_q[rd_ptr_q];
    assign head_wnr_o   = ctrl_q[rd_ptr_q].wnr;
    assign head_err_o   = ctrl_q[rd_ptr_q].err;
    assign head_data_o  = data_q[rd_ptr_q];

    // Occupancy next state; simultaneous push and pop cancel out.
    always_comb begin
        occ_d = occ_q + OccW'(push_i) - OccW'(pop_i);
    end

    // Pointers, valids and counters; counters saturate at zero while the entry waits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                ctrl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (vld_q[i] && (ctrl_q[i].cnt != '0)) begin
                    ctrl_q[i].cnt <= ctrl_q[i].cnt - 1'b1;
                end
            end
            if (push_i) begin
                ctrl_q[wr_ptr_q] <= '{wnr: push_wnr_i, err: push_err_i, cnt: LAT_W'(Lat - 1)};
                vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    // Payload storage needs no reset; it is only observed behind a valid entry.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            idx_q[wr_ptr_q]  <= push_idx_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mmu_mem_rsp.sv
// Memory responder for the MMU memory port: line array plus fixed-latency in-order responses.
module mmu_mem_rsp
    import mmu_mem_pkg::*;
#(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned MCN_W  = 52,
    parameter int unsigned PCN_W  = 24,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned AW     = 8,
    parameter int unsigned LAT    = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_req_o_valid,
    output logic              mem_req_o_ready,
    input  logic [IDX_W-1:0]  mem_req_o_bits_idx,
    input  logic              mem_req_o_bits_wnr,
    input  logic [MCN_W-1:0]  mem_req_o_bits_mcn,
    input  logic [PCN_W-1:0]  mem_req_o_bits_pcn,
    input  logic [DATA_W-1:0] mem_req_o_bits_data,
    output logic              mem_res_i_valid,
    input  logic              mem_res_i_ready,
    output logic [IDX_W-1:0]  mem_res_i_bits_idx,
    output logic              mem_res_i_bits_err,
    output logic              mem_res_i_bits_wnr,
    output logic [DATA_W-1:0] mem_res_i_bits_data
);

    localparam int unsigned Lines = 2 ** AW;

    logic [DATA_W-1:0] mem_q [Lines];
    logic              full;
    logic              accept;
    logic              req_err;
    logic              pop;
    logic [AW-1:0]     line;
    logic [DATA_W-1:0] rsp_data;
    logic              head_ready;
    logic [IDX_W-1:0]  head_idx;
    logic              head_wnr;
    logic              head_err;
    logic [DATA_W-1:0] head_data;
    logic              unused_mcn;

    // The MCN travels with the request but has no meaning here.
    assign unused_mcn = ^mem_req_o_bits_mcn;

    assign accept  = mem_req_o_valid && !full;
    assign req_err = pcn_err(PCN_MAX_W'(mem_req_o_bits_pcn), AW);
    assign line    = mem_req_o_bits_pcn[AW-1:0];
    // Read data is the array content before this edge; writes of earlier edges are already in.
    assign rsp_data = (mem_req_o_bits_wnr || req_err) ? '0 : mem_q[line];
    assign pop      = head_ready && mem_res_i_ready;

    // Line array; out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (accept && mem_req_o_bits_wnr && !req_err) begin
            mem_q[line] <= mem_req_o_bits_data;
        end
    end

    mmu_mem_rsp_q #(
        .Depth (DEPTH),
        .IdxW  (IDX_W),
        .DataW (DATA_W),
        .Lat   (LAT)
    ) u_rsp_q (
        .clk_i        (clock),
        .rst_ni       (reset),
        .push_i       (accept),
        .push_idx_i   (mem_req_o_bits_idx),
        .push_wnr_i   (mem_req_o_bits_wnr),
        .push_err_i   (req_err),
        .push_data_i  (rsp_data),
        .pop_i        (pop),
        .full_o       (full),
        .head_ready_o (head_ready),
        .head_idx_o   (head_idx),
        .head_wnr_o   (head_wnr),
        .head_err_o   (head_err),
        .head_data_o  (head_data)
    );

    // Outputs come from registered queue state only; bits read as zero when no response is up.
    assign mem_req_o_ready     = !full;
    assign mem_res_i_valid     = head_ready;
    assign mem_res_i_bits_idx  = head_ready ? head_idx : '0;
    assign mem_res_i_bits_wnr  = head_ready && head_wnr;
    assign mem_res_i_bits_err  = head_ready && head_err;
    assign mem_res_i_bits_data = head_ready ? head_data : '0;

endmodule

// File: tb/tb_mmu_mem_rsp.sv
// Bench for mmu_mem_rsp: two instances (LAT=4 and LAT=1, DEPTH=4) share stimulus and are
// compared every cycle against a transaction-level model of accepted requests.
module tb_mmu_mem_rsp;

    localparam int DEPTH = 4;
    localparam int LAT0  = 4;
    localparam int LAT1  = 1;

    typedef struct {
        logic [3:0]   idx;
        logic         wnr;
        logic         err;
        logic [511:0] data;
        int           t;
    } rsp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic [3:0]   req_idx = '0;
    logic         req_wnr = 1'b0;
    logic [51:0]  req_mcn = '0;
    logic [23:0]  req_pcn = '0;
    logic [511:0] req_data = '0;
    logic         res_ready = 1'b0;

    logic [1:0]   rdy;
    logic [1:0]   vld;
    logic [1:0]   rerr;
    logic [1:0]   rwnr;
    logic [3:0]   ridx  [2];
    logic [511:0] rdata [2];

    // Reference model state: per-instance memory image and FIFO of expected responses.
    logic [511:0] mem_m [2][256];
    rsp_t         mq [2][8];
    int           mh [2];
    int           mn [2];
    int           acc [2];
    int           mlat [2];
    int           cyc;
    int           checks;
    int           failures;

    always #5 clock = ~clock;

    mmu_mem_rsp #(.LAT(LAT0), .DEPTH(DEPTH)) u_dut0 (
        .clock               (clock),
        .reset               (reset),
        .mem_req_o_valid     (req_valid),
        .mem_req_o_ready     (rdy[0]),
        .mem_req_o_bits_idx  (req_idx),
        .mem_req_o_bits_wnr  (req_wnr),
        .mem_req_o_bits_mcn  (req_mcn),
        .mem_req_o_bits_pcn  (req_pcn),
        .mem_req_o_bits_data (req_data),
        .mem_res_i_valid     (vld[0]),
        .mem_res_i_ready     (res_ready),
        .mem_res_i_bits_idx  (ridx[0]),
        .mem_res_i_bits_err  (rerr[0]),
        .mem_res_i_bits_wnr  (rwnr[0]),
        .mem_res_i_bits_data (rdata[0])
    );

    mmu_mem_rsp #(.LAT(LAT1), .DEPTH(DEPTH)) u_dut1 (
        .clock               (clock),
        .reset               (reset),
        .mem_req_o_valid     (req_valid),
        .mem_req_o_ready     (rdy[1]),
        .mem_req_o_bits_idx  (req_idx),
        .mem_req_o_bits_wnr  (req_wnr),
        .mem_req_o_bits_mcn  (req_mcn),
        .mem_req_o_bits_pcn  (req_pcn),
        .mem_req_o_bits_data (req_data),
        .mem_res_i_valid     (vld[1]),
        .mem_res_i_ready     (res_ready),
        .mem_res_i_bits_idx  (ridx[1]),
        .mem_res_i_bits_err  (rerr[1]),
        .mem_res_i_bits_wnr  (rwnr[1]),
        .mem_res_i_bits_data (rdata[1])
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic v, input logic w, input logic [23:0] pcn,
                        input logic [511:0] d, input logic [3:0] id, input logic rr);
        logic [1:0] er;
        logic [1:0] ev;
        rsp_t       h;
        rsp_t       n;
        req_valid = v;
        req_wnr   = w;
        req_pcn   = pcn;
        req_data  = d;
        req_idx   = id;
        req_mcn   = {$urandom, $urandom_range(0, 1048575)};
        res_ready = rr;
        for (int k = 0; k < 2; k++) begin
            er[k] = (mn[k] < DEPTH);
            ev[k] = (mn[k] > 0) && (cyc >= mq[k][mh[k]].t + mlat[k] - 1);
            chk($sformatf("ready%0d@%0d", k, cyc), 512'(rdy[k]), 512'(er[k]));
            chk($sformatf("valid%0d@%0d", k, cyc), 512'(vld[k]), 512'(ev[k]));
            if (ev[k]) begin
                h = mq[k][mh[k]];
                chk($sformatf("idx%0d@%0d", k, cyc), 512'(ridx[k]), 512'(h.idx));
                chk($sformatf("wnr%0d@%0d", k, cyc), 512'(rwnr[k]), 512'(h.wnr));
                chk($sformatf("err%0d@%0d", k, cyc), 512'(rerr[k]), 512'(h.err));
                chk($sformatf("data%0d@%0d", k, cyc), rdata[k], h.data);
            end
        end
        @(posedge clock);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (ev[k] && rr) begin
                mh[k] = (mh[k] + 1) % 8;
                mn[k]--;
            end
            if (v && er[k]) begin
                n.idx  = id;
                n.wnr  = w;
                n.err  = (pcn >= 24'd256);
                n.data = (w || n.err) ? '0 : mem_m[k][pcn[7:0]];
                n.t    = cyc;
                if (w && !n.err) mem_m[k][pcn[7:0]] = d;
                mq[k][(mh[k] + mn[k]) % 8] = n;
                mn[k]++;
                acc[k]++;
            end
        end
        #1;
    endtask

    // Hold a request until both instances have taken it at least once (bounded).
    task automatic send(input logic w, input logic [23:0] pcn, input logic [511:0] d,
                        input logic [3:0] id);
        int a0;
        int a1;
        a0 = acc[0];
        a1 = acc[1];
        for (int n = 0; n < 40 && (acc[0] == a0 || acc[1] == a1); n++) step(1'b1, w, pcn, d, id, 1'b1);
        chk("send_accepted", 512'((acc[0] != a0) && (acc[1] != a1)), 512'(1));
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, '0, 4'h0, rr);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        mlat[0]  = LAT0;
        mlat[1]  = LAT1;
        for (int k = 0; k < 2; k++) begin
            mh[k]  = 0;
            mn[k]  = 0;
            acc[k] = 0;
        end

        // Reset values.
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), 512'(rdy[k]), 512'(1));
            chk($sformatf("rst_valid%0d", k), 512'(vld[k]), 512'(0));
            chk($sformatf("rst_idx%0d", k), 512'(ridx[k]), 512'(0));
            chk($sformatf("rst_err%0d", k), 512'(rerr[k]), 512'(0));
            chk($sformatf("rst_wnr%0d", k), 512'(rwnr[k]), 512'(0));
            chk($sformatf("rst_data%0d", k), rdata[k], '0);
        end
        repeat (2) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        reset = 1'b1;

        // Fill the whole array with known data so every later read has a defined answer.
        for (int i = 0; i < 256; i++) send(1'b1, 24'(i), rnd512(), 4'(i));
        idle(8, 1'b1);

        // Basic latency: write then read line 0x10.
        send(1'b1, 24'h10, {64{8'hA5}}, 4'h3);
        send(1'b0, 24'h10, '0, 4'h4);
        idle(8, 1'b1);

        // Out of range: read 0x100, write 0x100, read line 0.
        send(1'b0, 24'h100, '0, 4'h5);
        send(1'b1, 24'h100, {16{32'hDEADBEEF}}, 4'h6);
        send(1'b0, 24'h000, '0, 4'h7);
        idle(8, 1'b1);

        // Full and backpressure: six requests into a stalled responder, long stall, release.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'(8 * i + 1), '0, 4'(8 + i), 1'b0);
        idle(10, 1'b0);
        // Full with a head leaving: request refused this cycle, taken the next.
        step(1'b1, 1'b0, 24'h42, '0, 4'hE, 1'b1);
        step(1'b1, 1'b0, 24'h42, '0, 4'hE, 1'b1);
        idle(10, 1'b1);

        // Streaming: 32 back-to-back reads with the response side always ready.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 24'($urandom_range(0, 255)), '0, 4'(i), 1'b1);
        idle(8, 1'b1);

        // Randomized mix of reads, writes, out-of-range lines and response stalls.
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 24'($urandom_range(256, 4000))
                                             : 24'($urandom_range(0, 255)),
                 rnd512(), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        // Reset mid-operation: a committed write plus three outstanding reads.
        send(1'b1, 24'h22, {16{32'h600DF00D}}, 4'h1);
        idle(6, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'(i + 3), '0, 4'(i + 2), 1'b0);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_valid%0d", k), 512'(vld[k]), 512'(0));
            chk($sformatf("midrst_ready%0d", k), 512'(rdy[k]), 512'(1));
            mh[k] = 0;
            mn[k] = 0;
        end
        repeat (2) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        reset = 1'b1;
        idle(8, 1'b1);
        send(1'b0, 24'h22, '0, 4'h9);
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_mem_rsp.md
# mmu_mem_rsp

Synthesizable memory responder for the MMU's memory port: the far end of the `mem_req_o` / `mem_res_i` channel pair. It accepts MMU memory requests, commits writes to and reads from a small line-granular backing array, and returns in-order responses after a fixed programmable latency with backpressure. It replaces behavioural memory models in the MMU bench and serves as the memory stub in FPGA bring-up.

## Interface
- `IDX_W`, 4: request/response tag width.
- `MCN_W`, 52: MCN width; carried but not interpreted.
- `PCN_W`, 24: physical cache-line number width.
- `DATA_W`, 512: line data width.
- `AW`, 8: backing array address width, 2^AW lines.
- `LAT`, 4: request-to-response latency in cycles, legal range 1..15.
- `DEPTH`, 4: maximum outstanding requests, power of two, at least 2.

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `mem_req_o_valid`  in  1: request valid.
- `mem_req_o_ready`  out  1: request accepted when high together with valid.
- `mem_req_o_bits_idx`  in  IDX_W: tag.
- `mem_req_o_bits_wnr`  in  1: 1 = write, 0 = read.
- `mem_req_o_bits_mcn`  in  MCN_W: ignored.
- `mem_req_o_bits_pcn`  in  PCN_W: line address.
- `mem_req_o_bits_data`  in  DATA_W: write data.
- `mem_res_i_valid`  out  1: response valid.
- `mem_res_i_ready`  in  1: response consumed when high together with valid.
- `mem_res_i_bits_idx`  out  IDX_W: echoed tag.
- `mem_res_i_bits_err`  out  1: address error.
- `mem_res_i_bits_wnr`  out  1: echoed direction.
- `mem_res_i_bits_data`  out  DATA_W: read data.

## Operation
- **Accept:** a request is accepted when `valid && ready`. `ready = !full`, with no full-bypass: a simultaneous dequeue does not free a slot in the same cycle.
- **Range check:** `err = |pcn[PCN_W-1:AW]`. The array index is `pcn[AW-1:0]`.
- **Writes:**
  - An in-range write updates the array at the acceptance edge.
  - An out-of-range write is dropped, but still produces a response with `err = 1`.
- **Reads:**
  - An in-range read samples the array at the acceptance edge, so it sees every earlier-accepted write, including one accepted in the previous cycle.
  - An out-of-range read returns data 0.
- **Response data:** write responses carry data 0.
- **Queue entry:** `{idx, wnr, err, data, cnt[3:0]}`. On accept, `cnt = LAT-1`.
  - Every cycle, every valid entry with `cnt != 0` decrements.
  - A counter saturates at 0 while its entry waits.
- **Ordering:** responses are strictly in acceptance order.
- **Response valid:** `mem_res_i_valid = head_valid && head.cnt == 0`. Response bits are driven from the head entry.
- **Stability:** while `valid && !ready`, all response outputs hold stable. Younger entries keep counting down, so back-to-back responses follow immediately once stalling ends.
- **Reset:** clears queue pointers, occupancy and all entry valids. Array contents are not reset.
  - Reset asserted mid-operation discards every outstanding request without a response.
  - A write already accepted before reset remains in the array.

## Timing
- **Reset values:** `mem_req_o_ready = 1`, `mem_res_i_valid = 0`, `idx = 0`, `err = 0`, `wnr = 0`, `data = 0`.
- **Latency:** a request accepted at edge T raises `mem_res_i_valid` in the cycle after edge T+LAT-1. LAT=1 means the response is visible the cycle immediately after acceptance.
- **Throughput:**
  - Sustained: one request per cycle with `res_ready` tied high and DEPTH ≥ LAT+1.
  - Otherwise `ready` drops once occupancy reaches DEPTH.
- **Pointers:** wrap modulo DEPTH. The occupancy counter is $clog2(DEPTH)+1 bits wide.
  - Full: `occ == DEPTH`. Empty: `occ == 0`.
  - Simultaneous enqueue and dequeue leaves `occ` unchanged.
- **Outputs:** no combinational path from `mem_res_i_ready` or `mem_req_o_valid` to any output. `ready` depends on registered occupancy only.

## Structure
- **Shared package `mmu_mem_pkg`:**
  - entry struct typedef;
  - `LAT_W = 4`;
  - helper function `pcn_err(pcn)`.
- **Sub-module `mmu_mem_rsp_q`:** parameterized DEPTH-entry FIFO with per-entry saturating down-counters and head-ready output.
- **Top level:** holds the array (a single-port RAM inferred as a register array), request decode and output muxing.

## Test plan
- **Basic latency:** LAT=4, write pcn 0x10 data 0xA5…, then read pcn 0x10 → write response `err=0 wnr=1 data=0`, then read response `data=0xA5…`. The first response is valid exactly 4 cycles after its accept.
- **Out-of-range:** AW=8, read pcn 0x100 → `err=1 data=0`. Write pcn 0x100 then read pcn 0x00 → array line 0 unchanged.
- **Full and backpressure:** DEPTH=4, `res_ready=0`, drive 6 requests → 4 accepted, `ready` low; outputs held stable across 10 stall cycles. Release → 4 responses on consecutive cycles, tags in order.
- **Streaming:** LAT=1, DEPTH=4, 32 back-to-back reads with `res_ready=1` → 32 accepts in 32 cycles, one response per cycle, zero bubbles.
- **Simultaneous full enqueue/dequeue:** queue full, head dequeued while a new request is presented → not accepted that cycle; accepted the following cycle.
- **Reset mid-operation:** 3 outstanding requests, assert `reset` low for 2 cycles → `res_valid=0`, `ready=1` immediately. No stale responses afterwards; a write accepted before reset reads back correctly.
